// File: rtl/axim_dma_pkg.sv
// Shared definitions for the AXI4 write-back DMA.
//   - dma_state_e     : job FSM states (IDLE -> AW -> DATA -> RESP -> DONE)
//   - AXI_BURST_INCR  : AWBURST encoding for incrementing bursts
//   - AXI_RESP_OKAY   : BRESP encoding for a successful write
//   - KB4_LIMIT       : AXI bursts must not cross this byte boundary
//   - beat_bytes_of() : bytes carried by one buffer row / AXI beat
//   - awsize_of()     : AWSIZE encoding for a given beat size in bytes
package axim_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_DATA = 3'd2,
    S_RESP = 3'd3,
    S_DONE = 3'd4
  } dma_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned KB4_LIMIT     = 4096;

  function automatic int unsigned beat_bytes_of(input int unsigned lanes,
                                                input int unsigned lane_bits);
    return (lanes * lane_bits) / 8;
  endfunction

  function automatic int unsigned awsize_of(input int unsigned bytes);
    return $clog2(bytes);
  endfunction

endpackage

// File: rtl/axim_skid_fifo.sv
// Two-entry FIFO holding buffer rows between the 1-cycle-latency buffer read
// and the AXI W channel. Absorbs wready backpressure without losing rows.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push/push_data : write one entry (caller guarantees not full)
//   pop          : remove head entry (caller guarantees not empty)
//   head_data    : current head entry
//   count        : number of stored entries (0..2)
module axim_skid_fifo #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/axim_writeback_dma.sv
// AXI4 write master that copies result rows from the Output Buffer to DDR.
// A start pulse in IDLE latches src row, dest byte address (beat aligned) and
// row count; the job is split into INCR bursts of at most MAX_BURST beats that
// never cross a 4KB boundary. One buffer row is one W beat.
// Ports:
//   axi_master_*      : control-unit job interface (start, params, done/err/busy)
//   axim_rd_*         : Output Buffer read port, data valid 1 cycle after rd_en
//   m_aw* / m_w* / m_b* : AXI4 write address, data and response channels
//   perf_cycles/perf_wstall : only with AXIM_PERF_CNT_EN defined
//   dbg_state         : current FSM state
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1; once valid is raised, it and its payload stay stable until then.
// Optional feature macro: AXIM_PERF_CNT_EN (job cycle and W-stall counters).
module axim_writeback_dma
  import axim_dma_pkg::*;
#(
  parameter int SYSTOLIC_ARRAY_WIDTH = 4,
  parameter int DATA_WIDTH_ACCUM     = 32,
  parameter int ADDR_WIDTH           = 10,
  parameter int AXI_ADDR_WIDTH       = 32,
  parameter int MAX_BURST            = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   axi_master_start_pulse,
  input  logic [AXI_ADDR_WIDTH-1:0]              axi_master_dest_addr,
  input  logic [ADDR_WIDTH-1:0]                  axi_master_src_addr,
  input  logic [15:0]                            axi_master_length,
  output logic                                   axi_master_done_irq,
  output logic                                   axi_master_err,
  output logic                                   axi_master_busy,
  output logic [ADDR_WIDTH-1:0]                  axim_rd_addr_in,
  output logic                                   axim_rd_en_in,
  input  logic [DATA_WIDTH_ACCUM-1:0]            axim_rd_data_out [SYSTOLIC_ARRAY_WIDTH],
  output logic [AXI_ADDR_WIDTH-1:0]              m_awaddr,
  output logic [7:0]                             m_awlen,
  output logic [2:0]                             m_awsize,
  output logic [1:0]                             m_awburst,
  output logic                                   m_awvalid,
  input  logic                                   m_awready,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM-1:0]   m_wdata,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM/8-1:0] m_wstrb,
  output logic                                   m_wlast,
  output logic                                   m_wvalid,
  input  logic                                   m_wready,
  input  logic [1:0]                             m_bresp,
  input  logic                                   m_bvalid,
  output logic                                   m_bready,
`ifdef AXIM_PERF_CNT_EN
  output logic [31:0]                            perf_cycles,
  output logic [31:0]                            perf_wstall,
`endif
  output logic [2:0]                             dbg_state
);

  localparam int unsigned ROW_BITS   = SYSTOLIC_ARRAY_WIDTH * DATA_WIDTH_ACCUM;
  localparam int unsigned BEAT_BYTES = beat_bytes_of(SYSTOLIC_ARRAY_WIDTH, DATA_WIDTH_ACCUM);
  localparam int unsigned AWSIZE     = awsize_of(BEAT_BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BEAT_BYTES - 1);

  dma_state_e                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]               remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]     rd_addr_q, rd_addr_d;
  logic                      err_q, err_d;
  logic [8:0]                rd_cnt_q, rd_cnt_d;   // reads issued in this burst
  logic [8:0]                wr_cnt_q, wr_cnt_d;   // beats accepted in this burst
  logic                      inflight_q, inflight_d;

  logic [ROW_BITS-1:0] row_data;
  logic [ROW_BITS-1:0] fifo_head;
  logic [1:0]          fifo_count;
  logic [12:0]         room_bytes;
  logic [12:0]         room_beats;
  logic [8:0]          beats;
  logic [2:0]          occupancy;
  logic                wvalid, wlast, pop, issue;

  for (genvar i = 0; i < SYSTOLIC_ARRAY_WIDTH; i++) begin : g_pack
    assign row_data[i*DATA_WIDTH_ACCUM +: DATA_WIDTH_ACCUM] = axim_rd_data_out[i];
  end

  axim_skid_fifo #(.WIDTH(ROW_BITS)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (row_data),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  // Current burst size. addr_q/remaining_q only change when leaving RESP, so
  // this stays constant across AW, DATA and RESP of one burst.
  always_comb begin
    room_bytes = 13'(KB4_LIMIT) - {1'b0, addr_q[11:0]};
    room_beats = room_bytes >> AWSIZE;
    beats = (remaining_q > 16'(MAX_BURST)) ? 9'(MAX_BURST) : remaining_q[8:0];
    if ({4'b0, beats} > room_beats) begin
      beats = room_beats[8:0];
    end
  end

  always_comb begin
    wvalid    = (state_q == S_DATA) && (fifo_count != 2'd0);
    wlast     = (wr_cnt_q + 9'd1) == beats;
    pop       = wvalid && m_wready;
    // Rows already stored plus the one still coming back from the buffer must
    // leave room for the next read, counting the slot freed by this pop.
    occupancy = {1'b0, fifo_count} + {2'b0, inflight_q};
    issue     = ((state_q == S_AW) || (state_q == S_DATA)) &&
                (rd_cnt_q < beats) &&
                (occupancy < (3'd2 + {2'b0, pop}));
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    inflight_d  = issue;
    rd_addr_d   = rd_addr_q + {{(ADDR_WIDTH-1){1'b0}}, issue};
    rd_cnt_d    = rd_cnt_q + {8'b0, issue};
    wr_cnt_d    = wr_cnt_q + {8'b0, pop};
    case (state_q)
      S_IDLE: begin
        if (axi_master_start_pulse) begin
          rd_addr_d   = axi_master_src_addr;
          addr_d      = axi_master_dest_addr & ALIGN_MASK;
          remaining_d = axi_master_length;
          err_d       = 1'b0;
          rd_cnt_d    = 9'd0;
          wr_cnt_d    = 9'd0;
          state_d     = (axi_master_length == 16'd0) ? S_DONE : S_AW;
        end
      end
      S_AW: begin
        if (m_awready) state_d = S_DATA;
      end
      S_DATA: begin
        if (pop && wlast) state_d = S_RESP;
      end
      S_RESP: begin
        if (m_bvalid) begin
          if (m_bresp != AXI_RESP_OKAY) err_d = 1'b1;
          addr_d      = addr_q + (AXI_ADDR_WIDTH'(beats) << AWSIZE);
          remaining_d = remaining_q - 16'(beats);
          rd_cnt_d    = 9'd0;
          wr_cnt_d    = 9'd0;
          state_d     = (remaining_q == 16'(beats)) ? S_DONE : S_AW;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      rd_addr_q   <= '0;
      err_q       <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      rd_addr_q   <= rd_addr_d;
      err_q       <= err_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

  // Payload fields are zeroed whenever their valid is low so the bus is quiet
  // outside a transfer and after reset.
  assign m_awvalid = (state_q == S_AW);
  assign m_awaddr  = m_awvalid ? addr_q : '0;
  assign m_awlen   = m_awvalid ? 8'(beats - 9'd1) : 8'd0;
  assign m_awsize  = m_awvalid ? 3'(AWSIZE) : 3'd0;
  assign m_awburst = m_awvalid ? AXI_BURST_INCR : 2'b00;
  assign m_wvalid  = wvalid;
  assign m_wdata   = wvalid ? fifo_head : '0;
  assign m_wstrb   = wvalid ? '1 : '0;
  assign m_wlast   = wvalid && wlast;
  assign m_bready  = (state_q == S_RESP);

  assign axi_master_done_irq = (state_q == S_DONE);
  assign axi_master_busy     = (state_q == S_AW) || (state_q == S_DATA) || (state_q == S_RESP);
  assign axi_master_err      = err_q;
  assign axim_rd_addr_in     = rd_addr_q;
  assign axim_rd_en_in       = issue;
  assign dbg_state           = state_q;

`ifdef AXIM_PERF_CNT_EN
  // perf_cycles counts the accepting cycle, every busy cycle and the DONE
  // cycle, then holds until the next accepted start.
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_wstall_q, perf_wstall_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_wstall_d = perf_wstall_q;
    if ((state_q == S_IDLE) && axi_master_start_pulse) begin
      perf_cycles_d = 32'd1;
      perf_wstall_d = 32'd0;
    end else begin
      if (state_q != S_IDLE) perf_cycles_d = perf_cycles_q + 32'd1;
      if (wvalid && !m_wready) perf_wstall_d = perf_wstall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_wstall_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_wstall_q <= perf_wstall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_wstall = perf_wstall_q;
`endif

endmodule

// File: doc/axim_writeback_dma.md
Name: axim_writeback_dma

Overview:
- AXI4 write master that moves result rows from the Output Buffer to external DDR.
- Triggered by the Control Unit's start pulse; uses the same handshake the Control Unit already drives: start pulse, src/dest/length, done IRQ.
- Reads the buffer through its rd_addr/rd_en port (1-cycle read latency) and issues INCR write bursts, one buffer row per beat.
- Sits between tpu_verification_top's AXI-Master read port and the SoC interconnect.

Parameters:
- SYSTOLIC_ARRAY_WIDTH, 4, lanes per row (W).
- DATA_WIDTH_ACCUM, 32, bits per lane.
- ADDR_WIDTH, 10, Output Buffer address width.
- AXI_ADDR_WIDTH, 32, AXI address width.
- MAX_BURST, 16, maximum beats per burst (1..256).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- axi_master_start_pulse  in  1  one-cycle job start.
- axi_master_dest_addr  in  AXI_ADDR_WIDTH  DDR byte address.
- axi_master_src_addr  in  ADDR_WIDTH  first buffer row.
- axi_master_length  in  16  row count.
- axi_master_done_irq  out  1  one-cycle job completion pulse.
- axi_master_err  out  1  sticky BRESP error for the current/last job.
- axi_master_busy  out  1  job in progress.
- axim_rd_addr_in  out  ADDR_WIDTH  buffer read address.
- axim_rd_en_in  out  1  buffer read enable.
- axim_rd_data_out  in  W x DATA_WIDTH_ACCUM (unpacked)  row data, valid 1 cycle after rd_en.
- m_awaddr  out  AXI_ADDR_WIDTH.
- m_awlen  out  8.
- m_awsize  out  3.
- m_awburst  out  2.
- m_awvalid  out  1.
- m_awready  in  1.
- m_wdata  out  W*DATA_WIDTH_ACCUM.
- m_wstrb  out  W*DATA_WIDTH_ACCUM/8.
- m_wlast  out  1.
- m_wvalid  out  1.
- m_wready  in  1.
- m_bresp  in  2.
- m_bvalid  in  1.
- m_bready  out  1.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE, counters clear, skid FIFO empties.
- Constants:
  - BEAT_BYTES = W*DATA_WIDTH_ACCUM/8.
  - m_awsize = log2(BEAT_BYTES).
  - m_awburst = 2'b01 (INCR).
  - m_wstrb is all ones.
- Alignment: dest_addr low log2(BEAT_BYTES) bits are forced to 0.
- Job start:
  - start_pulse in IDLE latches src, dest and length, clears err, and sets busy the next cycle.
  - start_pulse while busy is ignored.
- Zero length: length==0 gives done_irq one cycle after start, with no AXI traffic and busy held 0.
- FSM: IDLE -> AW -> DATA -> RESP -> (AW if rows remain, else DONE) -> IDLE.
- AW state:
  - Burst length = min(remaining, MAX_BURST, (4096 - addr[11:0]) / BEAT_BYTES). Bursts never cross a 4KB boundary.
  - awvalid is held, with stable fields, until awready.
- DATA state:
  - Beats stream in row order. wlast is set on the final beat of the burst.
  - wvalid and wdata are held stable until wready.
- RESP state:
  - bready = 1. On bvalid, a bresp != OKAY sets err (sticky until next start).
  - After the response, addr advances by beats*BEAT_BYTES and remaining decreases by beats.
- DONE state: done_irq = 1 for exactly one cycle; busy falls the same cycle.
- Read path:
  - Reads are prefetched only within the current burst, starting in AW.
  - rd_en is issued when (fifo_count + inflight - pop_this_cycle) < 2, for a 2-entry skid FIFO.
  - rd_addr increments per read issued.
  - Requirement: with wready held 1, sustain 1 beat/cycle after the first beat.
- Backpressure: no data loss or duplication under any wready/awready/bvalid pattern.
- Reset mid-burst: everything aborts immediately. No done_irq; outputs return to reset values.
- The buffer address wraps modulo 2^ADDR_WIDTH.

Optional Feature:
- Macro: AXIM_PERF_CNT_EN.
- When defined:
  - Adds output perf_cycles (32) = clk count from start acceptance to done_irq inclusive. It holds its value until the next start.
  - Adds output perf_wstall (32) = cycles with wvalid && !wready.
- When undefined: neither port nor any of the counter logic exists.

Decomposition:
- Package axim_dma_pkg holds:
  - the FSM state enum;
  - AXI_BURST_INCR and AXI_RESP_OKAY;
  - BEAT_BYTES/AWSIZE derivation functions;
  - the 4KB limit constant.
- Sub-module axim_skid_fifo: 2-entry FIFO of W*DATA_WIDTH_ACCUM bits with count output.

Test Plan:
1. src=40, dest=0x80000000, length=2, W=4:
   - Expect one AW with awaddr=0x80000000, awlen=1, awsize=4.
   - Beats are rows 40 and 41, wlast on beat 2.
   - After BRESP OKAY: done_irq pulses once, err=0.
2. length=20, MAX_BURST=16:
   - Expect AW at 0x80000000 with awlen=15, then AW at 0x80000100 with awlen=3.
   - 20 beats total in order, one done_irq.
3. dest=0x80000FE0, length=4:
   - Expect two bursts, awlen=1 each, at 0x80000FE0 and 0x80001000.
4. wready toggling 1/0 and awready delayed 3 cycles, length=8:
   - All 8 rows arrive in order with no duplicates.
   - With wready constant 1, beats are back-to-back.
5. length=0: done_irq the cycle after start, no awvalid. Error case, length=1 with bresp=SLVERR: err=1 at done_irq. A second start pulse mid-job is ignored.
6. rst_n low during DATA of a length=16 job:
   - All outputs 0 while reset is low; no done_irq.
   - A new job (length=2) afterwards completes correctly.
